// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one downstream SRAM-like port (req / addr_ok / data_ok) between the
// instruction-fetch master and the data master. Downstream responses come back
// in order, so a small ID FIFO remembers who issued each accepted request and
// steers every mem_data_ok to the right master. A starvation counter forces a
// waiting fetch through after STARVE_LIMIT back-to-back data accepts.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   inst_*                   fetch master (read-only, word size)
//   data_*                   data master (read/write, byte/half/word)
//   mem_*                    shared downstream port
//   pending_cnt              accepted-but-unanswered requests
//
// Parameters
//   DEPTH         max outstanding requests (power of two, 2..16)
//   STARVE_LIMIT  data accepts tolerated while fetch waits
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    // fetch master
    input  logic                     inst_req,
    input  logic [31:0]              inst_addr,
    output logic [31:0]              inst_rdata,
    output logic                     inst_addr_ok,
    output logic                     inst_data_ok,
    // data master
    input  logic                     data_req,
    input  logic                     data_wr,
    input  logic [1:0]               data_size,
    input  logic [31:0]              data_addr,
    input  logic [31:0]              data_wdata,
    input  logic [3:0]               data_wstrb,
    output logic [31:0]              data_rdata,
    output logic                     data_addr_ok,
    output logic                     data_data_ok,
    // downstream port
    output logic                     mem_req,
    output logic                     mem_wr,
    output logic [1:0]               mem_size,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic [31:0]              mem_rdata,
    input  logic                     mem_addr_ok,
    input  logic                     mem_data_ok,
    // status
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // ID FIFO: one bit per slot, pointers wrap naturally since DEPTH is 2^n
    logic [DEPTH-1:0] id_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [STV_W-1:0] starve_reg;
    logic             lock_reg;
    logic             lock_id_reg;

    logic grant;
    logic grant_req;
    logic fifo_full;
    logic fifo_empty;
    logic starve_hit;
    logic accept;
    logic pop;
    logic head_id;

    assign fifo_full  = (cnt_reg == CNT_W'(DEPTH));
    assign fifo_empty = (cnt_reg == '0);
    assign starve_hit = (starve_reg == STV_W'(STARVE_LIMIT));

    // A locked grant keeps the downstream request stable until it is accepted
    always_comb begin
        grant = ID_INST;
        if (lock_reg)
            grant = lock_id_reg;
        else if (starve_hit && inst_req)
            grant = ID_INST;
        else if (data_req)
            grant = ID_DATA;
    end

    assign grant_req = (grant == ID_DATA) ? data_req : inst_req;

    // Downstream drive: fetch is always a plain word read
    assign mem_req   = grant_req && !fifo_full;
    assign mem_wr    = (grant == ID_DATA) ? data_wr    : 1'b0;
    assign mem_size  = (grant == ID_DATA) ? data_size  : 2'd2;
    assign mem_addr  = (grant == ID_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (grant == ID_DATA) ? data_wdata : 32'd0;
    assign mem_wstrb = (grant == ID_DATA) ? data_wstrb : 4'd0;

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && (grant == ID_INST);
    assign data_addr_ok = accept && (grant == ID_DATA);

    // A response with nothing outstanding is dropped silently
    assign head_id      = id_reg[rd_ptr_reg];
    assign pop          = mem_data_ok && !fifo_empty;
    assign inst_data_ok = pop && (head_id == ID_INST);
    assign data_data_ok = pop && (head_id == ID_DATA);

    assign inst_rdata  = mem_rdata;
    assign data_rdata  = mem_rdata;
    assign pending_cnt = cnt_reg;

    // ID storage needs no reset: slots are only read once written
    always_ff @(posedge clk) begin
        if (accept)
            id_reg[wr_ptr_reg] <= grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            starve_reg  <= '0;
            lock_reg    <= 1'b0;
            lock_id_reg <= ID_INST;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;

            case ({accept, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase

            // Hold the grantee while the downstream stalls; a full FIFO
            // drops mem_req but leaves an existing lock in place
            if (accept) begin
                lock_reg <= 1'b0;
            end else if (mem_req) begin
                lock_reg    <= 1'b1;
                lock_id_reg <= grant;
            end

            if (!inst_req)
                starve_reg <= '0;
            else if (accept && grant == ID_INST)
                starve_reg <= '0;
            else if (accept && grant == ID_DATA && !starve_hit)
                starve_reg <= starve_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Directed bench for sram_port_arbiter. A queue-based reference model (owner
// queue, starvation count, held grant) predicts every combinational output on
// each falling edge; directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [2:0]  pending_cnt;

    always #5 clk = ~clk;

    sram_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .pending_cnt(pending_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state: owners of outstanding requests, oldest first
    bit m_q[$];
    int m_starve  = 0;
    bit m_lock    = 0;
    bit m_lock_id = 0;
    bit mon_en    = 0;

    // Downstream responder bookkeeping and observation logs
    int ds_out    = 0;
    bit auto_resp = 0;
    int resp_no   = 0;
    bit acc_log[$];
    bit dok_log[$];

    initial begin : monitor
        bit g, ereq, eacc, epop, ehead, full;
        g = 0; ereq = 0; eacc = 0; epop = 0; ehead = 0; full = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                full = (m_q.size() == DEPTH);
                if (m_lock)                              g = m_lock_id;
                else if (m_starve == LIMIT && inst_req)  g = 1'b0;
                else if (data_req)                       g = 1'b1;
                else                                     g = 1'b0;
                ereq  = (g ? data_req : inst_req) && !full;
                eacc  = ereq && mem_addr_ok;
                epop  = mem_data_ok && (m_q.size() > 0);
                ehead = epop ? m_q[0] : 1'b0;

                chk("mem_req",      32'(mem_req),      32'(ereq));
                chk("mem_addr",     mem_addr,          g ? data_addr : inst_addr);
                chk("mem_wr",       32'(mem_wr),       32'(g ? data_wr : 1'b0));
                chk("mem_size",     32'(mem_size),     32'(g ? data_size : 2'd2));
                chk("mem_wdata",    mem_wdata,         g ? data_wdata : 32'd0);
                chk("mem_wstrb",    32'(mem_wstrb),    32'(g ? data_wstrb : 4'd0));
                chk("inst_addr_ok", 32'(inst_addr_ok), 32'(eacc && !g));
                chk("data_addr_ok", 32'(data_addr_ok), 32'(eacc && g));
                chk("inst_data_ok", 32'(inst_data_ok), 32'(epop && !ehead));
                chk("data_data_ok", 32'(data_data_ok), 32'(epop && ehead));
                chk("pending_cnt",  32'(pending_cnt),  32'(m_q.size()));
                chk("inst_rdata",   inst_rdata,        mem_rdata);
                chk("data_rdata",   data_rdata,        mem_rdata);

                if (inst_addr_ok) acc_log.push_back(1'b0);
                if (data_addr_ok) acc_log.push_back(1'b1);
                if (inst_data_ok) dok_log.push_back(1'b0);
                if (data_data_ok) dok_log.push_back(1'b1);
            end
            if (mem_req && mem_addr_ok) ds_out++;
            if (mem_data_ok && ds_out > 0) ds_out--;

            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_starve  = 0;
                m_lock    = 0;
                m_lock_id = 0;
                ds_out    = 0;
            end else if (mon_en) begin
                if (epop) void'(m_q.pop_front());
                if (eacc) m_q.push_back(g);
                if (eacc) m_lock = 0;
                else if (ereq) begin
                    m_lock    = 1;
                    m_lock_id = g;
                end
                if (!inst_req)                          m_starve = 0;
                else if (eacc && !g)                    m_starve = 0;
                else if (eacc && g && m_starve < LIMIT) m_starve++;
            end
        end
    end

    // Advance to just after the next rising edge; optionally answer one
    // outstanding downstream request per cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_resp) begin
            mem_data_ok = (ds_out > 0);
            if (ds_out > 0) begin
                mem_rdata = 32'hA500_0000 + 32'(resp_no);
                resp_no++;
            end
        end
    endtask

    task automatic drain();
        auto_resp = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ds_out == 0) break;
        end
        auto_resp   = 0;
        mem_data_ok = 0;
        chk("drain_outstanding", 32'(ds_out), 32'd0);
        @(negedge clk);
        chk("drain_cnt", 32'(pending_cnt), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit d_acc, i_acc, done;
        int data_left;
        d_acc = 0; i_acc = 0; done = 0; data_left = 0;

        rst = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_size = 2'd2; data_addr = 0; data_wdata = 0; data_wstrb = 0;
        mem_rdata = 32'h1234_5678; mem_addr_ok = 0; mem_data_ok = 0;
        repeat (3) tick();
        rst = 0;
        mon_en = 1;

        // reset state
        @(negedge clk);
        chk("rst_cnt",     32'(pending_cnt), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_oks",     32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        chk("rst_rdata",   inst_rdata, 32'h1234_5678);

        // fetch only
        tick(); inst_req = 1; inst_addr = 32'hBFC0_0000; mem_addr_ok = 1;
        @(negedge clk);
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("t1_cnt0", 32'(pending_cnt), 32'd0);
        tick(); inst_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        chk("t1_cnt1", 32'(pending_cnt), 32'd1);
        tick(); mem_data_ok = 1; mem_rdata = 32'h3C1D_0000;
        @(negedge clk);
        chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C1D_0000);
        chk("t1_data_data_ok", 32'(data_data_ok), 32'd0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("t1_cnt_end", 32'(pending_cnt), 32'd0);

        // both request: data first, inst after data drops
        tick(); inst_req = 1; inst_addr = 32'hBFC0_0004; data_req = 1; data_wr = 0;
        data_size = 2'd2; data_addr = 32'h1000_0040; mem_addr_ok = 1;
        @(negedge clk);
        chk("t2_data_first", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_wait", 32'(inst_addr_ok), 32'd0);
        tick(); data_req = 0;
        @(negedge clk);
        chk("t2_inst_next", 32'(inst_addr_ok), 32'd1);
        tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDA7A_0001;
        @(negedge clk);
        chk("t2_pop1_data", 32'(data_data_ok), 32'd1);
        chk("t2_pop1_inst", 32'(inst_data_ok), 32'd0);
        chk("t2_data_rdata", data_rdata, 32'hDA7A_0001);
        tick(); mem_rdata = 32'h0000_0002;
        @(negedge clk);
        chk("t2_pop2_inst", 32'(inst_data_ok), 32'd1);
        chk("t2_pop2_data", 32'(data_data_ok), 32'd0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("t2_cnt_end", 32'(pending_cnt), 32'd0);

        // starvation: 10 writes vs one waiting fetch
        tick();
        acc_log.delete(); dok_log.delete();
        auto_resp = 1; mem_addr_ok = 1;
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        data_req = 1; data_wr = 1; data_addr = 32'hA000_0000;
        data_wdata = 32'h5555_0000; data_wstrb = 4'hF; data_left = 10;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            d_acc = data_addr_ok;
            i_acc = inst_addr_ok;
            tick();
            if (d_acc) begin
                data_left--;
                data_addr  = data_addr + 32'd4;
                data_wdata = data_wdata + 32'd1;
            end
            data_req = (data_left > 0);
            if (i_acc) inst_req = 0;
            done = (data_left == 0) && !inst_req && (dok_log.size() >= 11);
            if (done) break;
        end
        auto_resp = 0; mem_data_ok = 0; mem_addr_ok = 0;
        chk("t3_complete", 32'(done), 32'd1);
        chk("t3_acc_count", 32'(acc_log.size()), 32'd11);
        for (int i = 0; i < 8; i++) chk("t3_acc_data", 32'(acc_log[i]), 32'd1);
        chk("t3_acc9_inst", 32'(acc_log[8]), 32'd0);
        chk("t3_acc10_data", 32'(acc_log[9]), 32'd1);
        chk("t3_acc11_data", 32'(acc_log[10]), 32'd1);
        chk("t3_resp8_data", 32'(dok_log[7]), 32'd1);
        chk("t3_resp9_inst", 32'(dok_log[8]), 32'd0);
        chk("t3_resp10_data", 32'(dok_log[9]), 32'd1);
        @(negedge clk);

        // FIFO full: four accepts, stall, then pop and re-accept
        tick(); data_req = 1; data_wr = 0; data_addr = 32'h8000_0000; data_wstrb = 4'h0;
        mem_addr_ok = 1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            chk("t4_fill_acc", 32'(data_addr_ok), 32'd1);
            tick();
        end
        @(negedge clk);
        chk("t4_full_req", 32'(mem_req), 32'd0);
        chk("t4_full_cnt", 32'(pending_cnt), 32'd4);
        tick(); mem_data_ok = 1; mem_rdata = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("t4_pop_dok", 32'(data_data_ok), 32'd1);
        chk("t4_pop_no_acc", 32'(data_addr_ok), 32'd0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("t4_reaccept", 32'(data_addr_ok), 32'd1);
        chk("t4_cnt3", 32'(pending_cnt), 32'd3);
        tick(); data_req = 0; mem_addr_ok = 0;
        drain();

        // stalled fetch keeps the port while data arrives
        tick(); inst_req = 1; inst_addr = 32'hBFC0_0200; mem_addr_ok = 0;
        @(negedge clk);
        chk("t5_c0_req", 32'(mem_req), 32'd1);
        chk("t5_c0_addr", mem_addr, 32'hBFC0_0200);
        tick(); data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h0000_0100;
        data_wdata = 32'hBEEF_CAFE; data_wstrb = 4'h3;
        @(negedge clk);
        chk("t5_c1_addr", mem_addr, 32'hBFC0_0200);
        chk("t5_c1_no_data", 32'(data_addr_ok), 32'd0);
        tick();
        @(negedge clk);
        chk("t5_c2_addr", mem_addr, 32'hBFC0_0200);
        tick(); mem_addr_ok = 1;
        @(negedge clk);
        chk("t5_c3_inst_acc", 32'(inst_addr_ok), 32'd1);
        chk("t5_c3_wr", 32'(mem_wr), 32'd0);
        tick(); inst_req = 0;
        @(negedge clk);
        chk("t5_c4_data_acc", 32'(data_addr_ok), 32'd1);
        chk("t5_c4_addr", mem_addr, 32'h0000_0100);
        chk("t5_c4_wstrb", 32'(mem_wstrb), 32'h3);
        tick(); data_req = 0; mem_addr_ok = 0; data_size = 2'd2;
        drain();

        // reset with three outstanding, then a stray response
        tick(); data_req = 1; data_wr = 0; data_addr = 32'h9000_0000; mem_addr_ok = 1;
        repeat (3) begin
            @(negedge clk);
            tick();
        end
        data_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        chk("t6_cnt3", 32'(pending_cnt), 32'd3);
        tick(); rst = 1;
        @(negedge clk);
        tick(); rst = 0;
        @(negedge clk);
        chk("t6_rst_cnt", 32'(pending_cnt), 32'd0);
        chk("t6_rst_oks", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'd0);
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        tick(); mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t6_stray_inst", 32'(inst_data_ok), 32'd0);
        chk("t6_stray_data", 32'(data_data_ok), 32'd0);
        chk("t6_stray_cnt", 32'(pending_cnt), 32'd0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("t6_final_cnt", 32'(pending_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Shares one downstream SRAM-like port (req/addr_ok/data_ok protocol) between the instruction-fetch master and the data master. The data master is normally the store-buffer output. Sits between the CPU-side fetch/buffer logic and the unified cache/AXI bridge. Responses are returned in order, so an ID FIFO routes each data_ok back to the master that issued the request. A starvation counter bounds how long fetch can be locked out by a burst of data accesses.

Parameters:
DEPTH, 4, max outstanding accepted-but-unanswered requests; power of two, 2..16
STARVE_LIMIT, 8, consecutive data accepts while inst waits before inst is forced to win

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address (read, 4 bytes)
inst_rdata  out  32  = mem_rdata
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0/1/2 = byte/half/word
data_addr  in  32  data address
data_wdata  in  32  write data
data_wstrb  in  4  byte strobes
data_rdata  out  32  = mem_rdata
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response/write-ack valid
mem_req  out  1  downstream request
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wstrb  out  4  downstream strobes
mem_rdata  in  32  downstream read data
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream response, in order, at least 1 cycle after its addr_ok
pending_cnt  out  clog2(DEPTH)+1  outstanding count

Behaviour:
- Reset state: ID FIFO empty, pending_cnt=0, starve counter 0, lock clear. All *_addr_ok, *_data_ok and mem_req are 0. rdata outputs follow mem_rdata.
- Grant selection (comb):
  - If lock is set, grant = lock_id.
  - Else if starve==STARVE_LIMIT and inst_req, grant = inst.
  - Else if data_req, grant = data.
  - Else grant = inst.
- Downstream drive:
  - mem_req = grantee's req && !fifo_full.
  - When inst is granted: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0, mem_addr=inst_addr.
  - When data is granted: data_* passes straight through.
- Accept: accept = mem_req && mem_addr_ok. The grantee's addr_ok = accept; the other master's addr_ok = 0. On accept, push the ID (0=inst, 1=data).
- Lock: set with lock_id=grant when mem_req && !mem_addr_ok; cleared on accept. This keeps the downstream request stable, with no grantee switch mid-handshake.
- Response routing:
  - On mem_data_ok with FIFO non-empty, pop the head. Assert inst_data_ok or data_data_ok for the head ID, same cycle, combinational from mem_data_ok.
  - mem_data_ok with FIFO empty is a protocol error: ignored, no data_ok asserted, count unchanged.
- Counting: push+pop in the same cycle leaves pending_cnt unchanged. Pointers wrap modulo DEPTH.
- Full: pending_cnt==DEPTH forces mem_req=0 (lock is held if set). Accept resumes the cycle after a pop.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on a data accept while inst_req=1.
  - Clears on an inst accept or whenever inst_req=0.
- Reset mid-operation: outstanding IDs are discarded. Downstream must be reset in the same cycle.

Test Plan:
- Fetch only: inst_req=1, addr 0xBFC00000; mem_addr_ok in cycle 1, mem_data_ok in cycle 3 with rdata 0x3C1D0000 -> inst_addr_ok in cycle 1, inst_data_ok in cycle 3 with inst_rdata 0x3C1D0000, data_data_ok=0, pending_cnt 0→1→0.
- Both masters request, mem_addr_ok=1 always -> data accepted first. Inst is accepted after data_req drops. The data response (first pop) raises data_data_ok only.
- data_req held high with 10 writes, inst_req high, STARVE_LIMIT=8 -> 8 data accepts, then 1 inst accept, then data resumes. The fetch response is routed in order, 9th.
- mem_data_ok withheld with DEPTH=4 -> 4 accepts, then mem_req=0 with pending_cnt=4. One mem_data_ok gives pop and re-accept in the next cycle.
- mem_addr_ok=0 for 3 cycles while inst is granted, and data_req rises in cycle 1 -> mem_addr stays at the inst address until accept. Data is granted afterward.
- Reset asserted with pending_cnt=3 -> next cycle pending_cnt=0, all *_ok=0. A stray mem_data_ok afterwards produces no data_ok.
